lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store initiator between the pipeline MEM stage and the word-organised, byte-strobed data memory.
- Accepts one load/store per handshake, encoded by RISC-V func3.
- Drives byte-lane strobes and shifted write data.
- Extracts and extends load data, and returns one in-order response per request. One transaction in flight at a time.

Parameters:
- AW, 32, byte-address width; memory word address is addr[AW-1:2].
- TIMEOUT, 0, cycles to wait for mem_gnt/mem_rvalid before error response; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  initiator can accept a request
- req_we  in  1  1=store, 0=load
- req_func3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_err  out  1  illegal func3, misaligned (see option), or timeout
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepted request this cycle
- mem_we  out  1  write enable
- mem_addr  out  AW  word-aligned address, bits[1:0]=0
- mem_be  out  4  byte strobes
- mem_wdata  out  32  lane-aligned write data
- mem_rvalid  in  1  completion for the granted request; read data valid on loads
- mem_rdata  in  32  read word

Behaviour:
- Reset values: all outputs 0, req_ready=1, FSM=IDLE. Reset mid-transaction abandons it; no response is issued.
- Request acceptance:
  - A request is accepted when req_valid && req_ready.
  - All request fields are registered on acceptance.
  - req_ready is 1 only in IDLE.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
  - IDLE -> ISSUE0 on accept; IDLE -> RESP with rsp_err=1 on illegal func3 (store func3 >= 011, load 011/11x).
  - ISSUE0: mem_req=1 and fields stable until mem_gnt. On gnt -> WAIT0.
  - WAIT0: on mem_rvalid, capture mem_rdata, then -> ISSUE1 if split, else -> RESP.
  - ISSUE1/WAIT1: as ISSUE0/WAIT0 at word address +4, then -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then -> IDLE. Earliest next accept is the cycle after RESP.
- Latency: aligned access with mem_gnt in the issue cycle and mem_rvalid the next cycle gives acceptance to rsp_valid = 3 cycles.
- Strobes (off = addr[1:0]):
  - B: be = 0001<<off.
  - H: be = 0011<<off.
  - W: be = 1111.
  - mem_wdata = req_wdata << (8*off).
  - Loads also drive be; the memory may ignore it.
- Load extraction:
  - byte/half is taken from data >> (8*off).
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W is passed through.
- Simultaneous mem_gnt and mem_rvalid in the same cycle (zero-latency memory) is legal: take the WAIT transition in the same cycle.
- mem_rvalid outside WAIT0/WAIT1 is ignored.
- Timeout (TIMEOUT>0): counter cleared on every state change; on expiry go to RESP with rsp_err=1 and mem_req dropped.
- Address wrap: the second word of a split at the top word address wraps to word 0.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined:
  - H at off=3 and W at off!=0 are split into two word accesses.
  - Store phase 0: be = low lanes of the shifted data. Phase 1: be and data carry the overflow lanes (be for W off=1 is 1110 then 0001).
  - Load: the two words are concatenated {w1,w0} and shifted right by 8*off before extension.
- Undefined: such accesses get no memory access and go IDLE -> RESP with rsp_err=1, rsp_rdata=0.

Decomposition:
- Package lsu_pkg:
  - func3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_e.
  - Function is_misaligned(func3, off).
- One combinational sub-module, lsu_load_align: inputs w0, w1, off, func3 -> extended 32-bit result.
- Strobe/shift logic stays in the top module.

Test Plan:
- Aligned store then load:
  - SW addr 0x10, data 0xDEADBEEF -> mem_be=1111, mem_addr=0x10.
  - LW 0x10 -> rsp_rdata=0xDEADBEEF, 3 cycles with instant gnt/rvalid.
- Byte/half lanes and extension:
  - SB addr 0x13, data 0x80 -> be=1000, wdata=0x80000000.
  - LB 0x13 on word 0x80000000 -> 0xFFFFFF80; LBU -> 0x00000080.
  - LH 0x12 on 0x8001xxxx -> 0xFFFF8001.
- Backpressure:
  - mem_gnt held low 5 cycles -> mem_req, mem_addr, mem_be stable; req_ready=0; single rsp after gnt and rvalid.
- Misaligned access:
  - LW 0x11 with words 0x44332211 @0x10 and 0x88776655 @0x14.
  - With LSU_MISALIGN_SPLIT_EN: two requests, rsp_rdata=0x55443322.
  - Without it: no mem_req, rsp_err=1.
- Illegal func3/timeout:
  - func3=011 load -> rsp_err=1, no mem_req.
  - TIMEOUT=8 with no rvalid -> rsp_err=1 after 8 cycles in WAIT0.
- Reset mid-operation:
  - rst asserted in WAIT0 -> next cycle all outputs 0, req_ready=1.
  - No rsp_valid; a later stale mem_rvalid is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store memory initiator.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package lsu_pkg;

    // RISC-V load/store size encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_WAIT0,
        S_ISSUE1,
        S_WAIT1,
        S_RESP
    } lsu_state_e;

    // An access that crosses a word boundary: half at byte 3, or any unaligned word
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] off);
        case (func3)
            F3_H, F3_HU: return (off == 2'd3);
            F3_W:        return (off != 2'd0);
            default:     return 1'b0;
        endcase
    endfunction

    // Stores only have B/H/W; loads additionally have BU/HU
    function automatic logic is_illegal(input logic we, input logic [2:0] func3);
        if (we) begin
            return func3[2] | (func3[1:0] == 2'b11);
        end
        return (func3 == 3'b011) | (func3[2:1] == 2'b11);
    endfunction

    // Unshifted byte-lane mask for the access size
    function automatic logic [3:0] size_mask(input logic [2:0] func3);
        case (func3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from one or two memory words and extends it.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // Concatenate so split accesses pull their upper bytes from the second word
    always_comb begin
        shifted = 32'({w1, w0} >> {off, 3'b000});
    end

    // Sign- or zero-extend according to the access type
    always_comb begin
        result = '0;
        case (func3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    result = shifted;
            F3_BU:   result = {24'b0, shifted[7:0]};
            F3_HU:   result = {16'b0, shifted[15:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator from the MEM stage to a word-organised byte-strobed memory.
// Latency: 3 cycles accept->rsp_valid for an aligned access with immediate gnt and next-cycle rvalid.
// Backpressure: req_ready only in IDLE; one transaction in flight; holds mem_* stable until mem_gnt.
// Build option LSU_MISALIGN_SPLIT_EN: split word-crossing accesses into two word transfers.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int          AW      = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_func3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata
);

    lsu_state_e    state_q, state_d;

    logic          we_q;
    logic [2:0]    func3_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   w0_q, w1_q;
    logic          err_q;
    logic [31:0]   tmo_cnt;

    logic          accept, set_err, cap0, cap1;
    logic          reject, split, waiting, tmo_hit;
    logic [1:0]    off;
    logic [7:0]    be_wide;
    logic [63:0]   wdata_wide;
    logic [AW-3:0] wa0, wa1;
    logic [31:0]   load_val;

    assign off = addr_q[1:0];

    // Shift over two words so the overflow lanes of a split access land in the upper half
    assign be_wide    = {4'b0, size_mask(func3_q)} << off;
    assign wdata_wide = {32'b0, wdata_q} << {off, 3'b000};

    // Second word of a split wraps naturally at the top of the address space
    assign wa0 = addr_q[AW-1:2];
    assign wa1 = wa0 + {{(AW-3){1'b0}}, 1'b1};

`ifdef LSU_MISALIGN_SPLIT_EN
    assign split  = is_misaligned(func3_q, off);
    assign reject = is_illegal(req_we, req_func3);
`else
    assign split  = 1'b0;
    assign reject = is_illegal(req_we, req_func3) | is_misaligned(req_func3, req_addr[1:0]);
`endif

    assign waiting = (state_q == S_ISSUE0) || (state_q == S_WAIT0) ||
                     (state_q == S_ISSUE1) || (state_q == S_WAIT1);
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TIMEOUT - 1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        set_err = 1'b0;
        cap0    = 1'b0;
        cap1    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (reject) begin
                        set_err = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE0;
                    end
                end
            end
            S_ISSUE0: begin
                if (mem_gnt) begin
                    if (mem_rvalid) begin
                        cap0    = 1'b1;
                        state_d = split ? S_ISSUE1 : S_RESP;
                    end else begin
                        state_d = S_WAIT0;
                    end
                end else if (tmo_hit) begin
                    set_err = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WAIT0: begin
                if (mem_rvalid) begin
                    cap0    = 1'b1;
                    state_d = split ? S_ISSUE1 : S_RESP;
                end else if (tmo_hit) begin
                    set_err = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_ISSUE1: begin
                if (mem_gnt) begin
                    if (mem_rvalid) begin
                        cap1    = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT1;
                    end
                end else if (tmo_hit) begin
                    set_err = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WAIT1: begin
                if (mem_rvalid) begin
                    cap1    = 1'b1;
                    state_d = S_RESP;
                end else if (tmo_hit) begin
                    set_err = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request fields, captured read words and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            func3_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                func3_q <= req_func3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                w0_q    <= '0;
                w1_q    <= '0;
                err_q   <= set_err;
            end else if (set_err) begin
                err_q   <= 1'b1;
            end
            if (cap0) begin
                w0_q <= mem_rdata;
            end
            if (cap1) begin
                w1_q <= mem_rdata;
            end
        end
    end

    // Per-state wait counter; restarts whenever the state moves
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state_d != state_q) begin
            tmo_cnt <= '0;
        end else if (waiting) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    // Memory port: driven only while issuing, zero otherwise
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0;
        mem_wdata = '0;
        if (state_q == S_ISSUE0) begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = {wa0, 2'b00};
            mem_be    = be_wide[3:0];
            mem_wdata = wdata_wide[31:0];
        end else if (state_q == S_ISSUE1) begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = {wa1, 2'b00};
            mem_be    = be_wide[7:4];
            mem_wdata = wdata_wide[63:32];
        end
    end

    lsu_load_align u_align (
        .w0     (w0_q),
        .w1     (w1_q),
        .off    (off),
        .func3  (func3_q),
        .result (load_val)
    );

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? load_val : 32'b0;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a behavioural word memory responder.
// Latency: n/a (testbench).
// Backpressure: responder can stall mem_gnt, withhold mem_rvalid or answer in the grant cycle.
module tb_lsu_mem_initiator;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.AW(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
        logic        err;
        int          nreq;
        int          lat;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  lbe;
        logic [31:0] laddr;
        logic [31:0] lwdata;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] mem [16];
    int          checks = 0;
    int          errors = 0;

    // responder state
    int          stall_left;
    bit          pend, rv_en, zl, force_rv, prev_stall;
    logic [3:0]  pend_idx;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_be;
    int          nreq;
    logic [3:0]  f_be, l_be;
    logic [31:0] f_addr, l_addr, f_wdata, l_wdata;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int dly, input logic [31:0] rdata,
                       input logic err, input int n, input int lat, input logic [3:0] be,
                       input logic [31:0] maddr, input logic [31:0] mwdata, input logic [3:0] lbe,
                       input logic [31:0] laddr, input logic [31:0] lwdata);
        vec_t t;
        t = '{we, f3, addr, wdata, dly, rdata, err, n, lat, be, maddr, mwdata, lbe, laddr, lwdata};
        vecs.push_back(t);
    endtask

    // One clock: memory responder acts at the falling edge, DUT samples at the rising edge
    task automatic tick();
        logic [3:0] idx;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (force_rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hCAFEF00D;
            force_rv   = 1'b0;
        end else if (pend && rv_en) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem[pend_idx];
            pend       = 1'b0;
        end
        mem_gnt = 1'b0;
        if (mem_req) begin
            if (prev_stall) begin
                chk("hold_addr", mem_addr, h_addr);
                chk("hold_be", 32'(mem_be), 32'(h_be));
                chk("hold_wdata", mem_wdata, h_wdata);
                chk("stall_ready", 32'(req_ready), 32'd0);
            end
            if (stall_left > 0) begin
                stall_left--;
                prev_stall = 1'b1;
                h_addr     = mem_addr;
                h_be       = mem_be;
                h_wdata    = mem_wdata;
            end else begin
                prev_stall = 1'b0;
                mem_gnt    = 1'b1;
                idx        = mem_addr[5:2];
                nreq++;
                if (nreq == 1) begin
                    f_be = mem_be; f_addr = mem_addr; f_wdata = mem_wdata;
                end
                l_be = mem_be; l_addr = mem_addr; l_wdata = mem_wdata;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[b]) mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                end
                if (zl) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[idx];
                end else begin
                    pend     = 1'b1;
                    pend_idx = idx;
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    endtask

    // Issue one request from IDLE and wait (bounded) for its response
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int dly,
                           output logic [31:0] rdata, output logic err, output int lat);
        req_valid  = 1'b1;
        req_we     = we;
        req_func3  = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        stall_left = dly;
        nreq       = 0;
        prev_stall = 1'b0;
        lat        = -1;
        rdata      = '0;
        err        = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 1) req_valid = 1'b0;
            if (rsp_valid) begin
                lat   = c;
                rdata = rsp_rdata;
                err   = rsp_err;
                break;
            end
        end
        chk("rsp_seen", 32'(lat != -1), 32'd1);
        tick();
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    endtask

    task automatic chk_idle(input string p);
        chk({p, "_ready"}, 32'(req_ready), 32'd1);
        chk({p, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({p, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({p, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({p, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({p, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({p, "_mem_addr"}, mem_addr, 32'd0);
        chk({p, "_mem_be"}, 32'(mem_be), 32'd0);
        chk({p, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, exp10, exp14;
        logic        er;
        int          lt;

        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = '0;
        req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        stall_left = 0; pend = 1'b0; rv_en = 1'b1; zl = 1'b0; force_rv = 1'b0; prev_stall = 1'b0;
        nreq = 0;

        // we  f3     addr          wdata        dly rdata        err n lat be    maddr         mwdata       lbe   laddr  lwdata
        add(1, F3_W,  32'h10,       32'hDEADBEEF, 0, 32'h0,        0, 1, 3, 4'hF, 32'h10,       32'hDEADBEEF, 4'h0, 32'h0, 32'h0);
        add(0, F3_W,  32'h10,       32'h0,        0, 32'hDEADBEEF, 0, 1, 3, 4'hF, 32'h10,       32'h0,        4'h0, 32'h0, 32'h0);
        add(1, F3_B,  32'h13,       32'h80,       0, 32'h0,        0, 1, 3, 4'h8, 32'h10,       32'h80000000, 4'h0, 32'h0, 32'h0);
        add(0, F3_B,  32'h13,       32'h0,        0, 32'hFFFFFF80, 0, 1, 3, 4'h8, 32'h10,       32'h0,        4'h0, 32'h0, 32'h0);
        add(0, F3_BU, 32'h13,       32'h0,        0, 32'h00000080, 0, 1, 3, 4'h8, 32'h10,       32'h0,        4'h0, 32'h0, 32'h0);
        add(1, F3_H,  32'h12,       32'h8001,     0, 32'h0,        0, 1, 3, 4'hC, 32'h10,       32'h80010000, 4'h0, 32'h0, 32'h0);
        add(0, F3_H,  32'h12,       32'h0,        0, 32'hFFFF8001, 0, 1, 3, 4'hC, 32'h10,       32'h0,        4'h0, 32'h0, 32'h0);
        add(0, F3_HU, 32'h12,       32'h0,        0, 32'h00008001, 0, 1, 3, 4'hC, 32'h10,       32'h0,        4'h0, 32'h0, 32'h0);
        add(0, F3_B,  32'h10,       32'h0,        0, 32'hFFFFFFEF, 0, 1, 3, 4'h1, 32'h10,       32'h0,        4'h0, 32'h0, 32'h0);
        add(0, F3_BU, 32'h11,       32'h0,        0, 32'h000000BE, 0, 1, 3, 4'h2, 32'h10,       32'h0,        4'h0, 32'h0, 32'h0);
        add(0, F3_H,  32'h11,       32'h0,        0, 32'h000001BE, 0, 1, 3, 4'h6, 32'h10,       32'h0,        4'h0, 32'h0, 32'h0);
        add(1, F3_W,  32'h10,       32'h44332211, 0, 32'h0,        0, 1, 3, 4'hF, 32'h10,       32'h44332211, 4'h0, 32'h0, 32'h0);
        add(1, F3_W,  32'h14,       32'h88776655, 0, 32'h0,        0, 1, 3, 4'hF, 32'h14,       32'h88776655, 4'h0, 32'h0, 32'h0);
        add(0, F3_B,  32'h12,       32'h0,        5, 32'h00000033, 0, 1, 8, 4'h4, 32'h10,       32'h0,        4'h0, 32'h0, 32'h0);
        add(0, 3'b011, 32'h10,      32'h0,        0, 32'h0,        1, 0, 1, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0, 32'h0);
        add(1, 3'b100, 32'h10,      32'h12,       0, 32'h0,        1, 0, 1, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0, 32'h0);
        add(0, 3'b110, 32'h10,      32'h0,        0, 32'h0,        1, 0, 1, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0, 32'h0);
        add(1, F3_W,  32'hFFFFFFFC, 32'h11223344, 0, 32'h0,        0, 1, 3, 4'hF, 32'hFFFFFFFC, 32'h11223344, 4'h0, 32'h0, 32'h0);
        add(1, F3_W,  32'h0,        32'h55667788, 0, 32'h0,        0, 1, 3, 4'hF, 32'h0,        32'h55667788, 4'h0, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
        add(0, F3_W,  32'h11,       32'h0,        0, 32'h55443322, 0, 2, 5, 4'hE, 32'h10,       32'h0,        4'h1, 32'h14, 32'h0);
        add(0, F3_H,  32'h13,       32'h0,        0, 32'h00005544, 0, 2, 5, 4'h8, 32'h10,       32'h0,        4'h1, 32'h14, 32'h0);
        add(1, F3_W,  32'h11,       32'hAABBCCDD, 0, 32'h0,        0, 2, 5, 4'hE, 32'h10,       32'hBBCCDD00, 4'h1, 32'h14, 32'h000000AA);
        add(0, F3_W,  32'hFFFFFFFD, 32'h0,        0, 32'h88112233, 0, 2, 5, 4'hE, 32'hFFFFFFFC, 32'h0,        4'h1, 32'h0,  32'h0);
        exp10 = 32'hBBCCDD11;
        exp14 = 32'h887766AA;
`else
        add(0, F3_W,  32'h11,       32'h0,        0, 32'h0,        1, 0, 1, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0, 32'h0);
        add(0, F3_H,  32'h13,       32'h0,        0, 32'h0,        1, 0, 1, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0, 32'h0);
        add(1, F3_W,  32'h11,       32'hAABBCCDD, 0, 32'h0,        1, 0, 1, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0, 32'h0);
        add(0, F3_W,  32'hFFFFFFFD, 32'h0,        0, 32'h0,        1, 0, 1, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0, 32'h0);
        exp10 = 32'h44332211;
        exp14 = 32'h88776655;
`endif
        add(0, F3_W,  32'h10,       32'h0,        0, exp10,        0, 1, 3, 4'hF, 32'h10,       32'h0,        4'h0, 32'h0, 32'h0);
        add(0, F3_W,  32'h14,       32'h0,        0, exp14,        0, 1, 3, 4'hF, 32'h14,       32'h0,        4'h0, 32'h0, 32'h0);

        // reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_idle("reset");

        // table-driven transactions
        foreach (vecs[i]) begin
            run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].dly, rd, er, lt);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].err));
            chk($sformatf("v%0d_lat", i), 32'(lt), 32'(vecs[i].lat));
            chk($sformatf("v%0d_nreq", i), 32'(nreq), 32'(vecs[i].nreq));
            if (vecs[i].nreq > 0) begin
                chk($sformatf("v%0d_be", i), 32'(f_be), 32'(vecs[i].be));
                chk($sformatf("v%0d_maddr", i), f_addr, vecs[i].maddr);
                chk($sformatf("v%0d_mwdata", i), f_wdata, vecs[i].mwdata);
            end
            if (vecs[i].nreq == 2) begin
                chk($sformatf("v%0d_be1", i), 32'(l_be), 32'(vecs[i].lbe));
                chk($sformatf("v%0d_maddr1", i), l_addr, vecs[i].laddr);
                chk($sformatf("v%0d_mwdata1", i), l_wdata, vecs[i].lwdata);
            end
        end

        // zero-latency memory: gnt and rvalid in the same cycle
        zl = 1'b1;
        run_txn(1'b0, F3_W, 32'h10, 32'h0, 0, rd, er, lt);
        zl = 1'b0;
        chk("zl_rdata", rd, exp10);
        chk("zl_lat", 32'(lt), 32'd2);
        chk("zl_err", 32'(er), 32'd0);

        // timeout waiting for rvalid: 8 cycles in WAIT0
        rv_en = 1'b0;
        run_txn(1'b0, F3_W, 32'h14, 32'h0, 0, rd, er, lt);
        chk("tmo_rv_err", 32'(er), 32'd1);
        chk("tmo_rv_rdata", rd, 32'd0);
        chk("tmo_rv_lat", 32'(lt), 32'd10);
        pend  = 1'b0;
        rv_en = 1'b1;

        // timeout waiting for gnt
        run_txn(1'b0, F3_W, 32'h14, 32'h0, 20, rd, er, lt);
        chk("tmo_gnt_err", 32'(er), 32'd1);
        chk("tmo_gnt_lat", 32'(lt), 32'd9);
        chk("tmo_gnt_nreq", 32'(nreq), 32'd0);
        chk("tmo_gnt_mem_req", 32'(mem_req), 32'd0);
        stall_left = 0;

        // reset while in WAIT0, then a stale rvalid must be ignored
        rv_en = 1'b0; nreq = 0; prev_stall = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_func3 = F3_W; req_addr = 32'h14; req_wdata = '0;
        tick();
        req_valid = 1'b0;
        chk("rst_granted", 32'(nreq), 32'd1);
        tick();
        chk("rst_in_wait_req", 32'(mem_req), 32'd0);
        chk("rst_in_wait_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("midrst");
        pend = 1'b0; rv_en = 1'b1; force_rv = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stale_rv_%0d", k), 32'(rsp_valid), 32'd0);
        end
        run_txn(1'b0, F3_W, 32'h14, 32'h0, 0, rd, er, lt);
        chk("post_rst_rdata", rd, exp14);
        chk("post_rst_lat", 32'(lt), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
